// File: rtl/seg_pkg.sv
// Shared constants for the 4-digit scanned 7-segment controller: segment
// patterns (a..g at bits 6..0, active-low), load FSM encoding and the value limit.
package seg_pkg;

  localparam int unsigned VAL_W = 14;
  localparam int unsigned BCD_W = 16;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned SEL_W = 4;

  localparam logic [VAL_W-1:0] MAX_VAL = 14'd9999;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_PEND = 2'd2
  } load_state_e;

  // Non-decimal codes fall through to blank.
  function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Value-load handshake and display drive bundle of seg_scan_ctrl.
interface seg_scan_ctrl_if;
  import seg_pkg::*;

  logic             in_valid;
  logic [VAL_W-1:0] in_value;
  logic             in_ready;
  logic             ovf;
  logic [SEG_W-1:0] display;
  logic [SEL_W-1:0] digit_select;

  modport master (
    output in_valid, in_value,
    input  in_ready, ovf, display, digit_select
  );

  modport slave (
    input  in_valid, in_value,
    output in_ready, ovf, display, digit_select
  );

endinterface

// File: rtl/bin2bcd14.sv
// 14-bit binary to 4-digit BCD, shift-add-3, one bit per cycle for 14 cycles.
module bin2bcd14
  import seg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [VAL_W-1:0] bin_i,
  output logic             busy_o,
  output logic             done_c,
  output logic [BCD_W-1:0] bcd_o
);

  localparam int unsigned      CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VAL_W - 1);

  logic [VAL_W-1:0] sh_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] adj;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (r[4*i +: 4] > 4'd4) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign adj = add3(bcd_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (busy_q) begin
      bcd_q <= {adj[BCD_W-2:0], sh_q[VAL_W-1]};
      sh_q  <= {sh_q[VAL_W-2:0], 1'b0};
      cnt_q <= cnt_q + CNT_W'(1);
      if (cnt_q == CNT_LAST) busy_q <= 1'b0;
    end else if (start_i) begin
      sh_q   <= bin_i;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end
  end

  // High during the final shift; bcd_o is complete after this edge.
  assign done_c = busy_q && (cnt_q == CNT_LAST);
  assign busy_o = busy_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit 7-segment controller: accepts a binary value, converts
// to BCD, swaps it into the display buffer only between scan frames.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 135000,
  parameter int unsigned BLANK_CYC = 1000,
  parameter bit          LZ_BLANK  = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  seg_scan_ctrl_if.slave  bus
);

  localparam int unsigned      CNT_W     = 20;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

  load_state_e      state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             ovf_q, ovf_d;
  logic [BCD_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       slot_q, slot_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEG_W-1:0] disp_q, disp_d;

  logic             transfer;
  logic             frame_end;
  logic [VAL_W-1:0] clamped;
  logic             conv_busy;
  logic             conv_done_c;
  logic [BCD_W-1:0] conv_bcd;
  logic [3:0]       digit;
  logic             lead_zero;

  assign transfer  = bus.in_valid && in_ready_q;
  assign clamped   = (bus.in_value > MAX_VAL) ? MAX_VAL : bus.in_value;
  assign frame_end = (slot_q == 2'd3) && (cnt_q == CNT_LAST);

  bin2bcd14 u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (transfer),
    .bin_i   (clamped),
    .busy_o  (conv_busy),
    .done_c  (conv_done_c),
    .bcd_o   (conv_bcd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
      ovf_q      <= 1'b0;
      buf_q      <= '0;
      cnt_q      <= '0;
      slot_q     <= '0;
      sel_q      <= '0;
      disp_q     <= SEG_BLANK;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      ovf_q      <= ovf_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      sel_q      <= sel_d;
      disp_q     <= disp_d;
    end
  end

  // Load FSM: the buffer is only rewritten on the last cycle of the ones slot.
  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    buf_d   = buf_q;
    case (state_q)
      ST_IDLE: begin
        if (transfer) begin
          state_d = ST_CONV;
          if (bus.in_value > MAX_VAL) ovf_d = 1'b1;
        end
      end
      ST_CONV: begin
        if (conv_done_c || !conv_busy) state_d = ST_PEND;
      end
      ST_PEND: begin
        if (frame_end) begin
          buf_d   = conv_bcd;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  // Scan timer, digit select and segment decode.
  always_comb begin
    cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    slot_d    = (cnt_q == CNT_LAST) ? slot_q + 2'd1 : slot_q;
    digit     = buf_q[3:0];
    lead_zero = 1'b0;
    case (slot_q)
      2'd0: begin digit = buf_q[15:12]; lead_zero = (buf_q[15:12] == 4'd0); end
      2'd1: begin digit = buf_q[11:8];  lead_zero = (buf_q[15:8]  == 8'd0); end
      2'd2: begin digit = buf_q[7:4];   lead_zero = (buf_q[15:4]  == 12'd0); end
      default: begin digit = buf_q[3:0]; lead_zero = 1'b0; end
    endcase
    sel_d  = '0;
    disp_d = SEG_BLANK;
    if (cnt_q >= BLANK_END) begin
      sel_d  = SEL_W'(4'b1000 >> slot_q);
      disp_d = (LZ_BLANK && lead_zero) ? SEG_BLANK : seg_decode(digit);
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.ovf          = ovf_q;
  assign bus.display      = disp_q;
  assign bus.digit_select = sel_q;

endmodule
